// File: rtl/spi_pkg.sv
// Shared SPI master register map and flash command constants.
// Used by the flash reader to build control-register writes and the read header.
package spi_pkg;

    localparam logic SPI_CTL  = 1'b0;
    localparam logic SPI_DATA = 1'b1;

    localparam int CTL_SS      = 0;
    localparam int CTL_DIV_LSB = 1;
    localparam int CTL_DIV_MSB = 3;
    localparam int CTL_BUSY    = 7;

    localparam logic [7:0] FLASH_READ = 8'h03;
    localparam int         HDR_BYTES  = 4;

    // Control word: clock divider in [3:1], slave-select level in bit 0, busy is read-only.
    function automatic logic [7:0] ctl_word(input logic [2:0] div, input logic ss);
        logic [7:0] w;
        w = '0;
        w[CTL_DIV_MSB:CTL_DIV_LSB] = div;
        w[CTL_SS]   = ss;
        w[CTL_BUSY] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: drives the SPI master's register bus with opcode,
// 24-bit address and dummy bytes, and streams received data bytes out.
module spi_flash_reader
    import spi_pkg::*;
#(
    parameter logic [7:0] CMD       = FLASH_READ,
    parameter logic [2:0] DIV       = 3'd2,
    parameter logic       SS_ACTIVE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [23:0] i_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_valid,
    output logic [7:0]  o_data,
    input  logic        i_ready,
    output logic        o_spi_addr,
    output logic        o_spi_cs,
    output logic        o_spi_we,
    output logic [7:0]  o_spi_dat,
    input  logic [7:0]  i_spi_dat,
    input  logic        i_spi_irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SS_ON,
        S_SEND,
        S_WAIT,
        S_PUSH,
        S_NEXT,
        S_SS_OFF,
        S_DONE
    } state_t;

    state_t      state;
    logic [23:0] addr_q;
    logic [15:0] len_q;
    logic [16:0] idx;
    logic [7:0]  rx;
    logic [16:0] end_idx;

    // 17-bit end index so a full 16'hFFFF length cannot wrap into the header range.
    assign end_idx = {1'b0, len_q} + 17'(HDR_BYTES);

    function automatic logic [7:0] tx_byte(input logic [16:0] i, input logic [23:0] a);
        logic [7:0] b;
        case (i)
            17'd0:   b = CMD;
            17'd1:   b = a[23:16];
            17'd2:   b = a[15:8];
            17'd3:   b = a[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Outputs are registered alongside the state: each branch loads the values
    // the destination state presents, so bus strobes line up with the state cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            idx        <= '0;
            rx         <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_spi_addr <= 1'b0;
            o_spi_cs   <= 1'b0;
            o_spi_we   <= 1'b0;
            o_spi_dat  <= '0;
        end else begin
            o_spi_cs <= 1'b0;
            o_spi_we <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        addr_q     <= i_addr;
                        len_q      <= i_len;
                        idx        <= '0;
                        o_busy     <= 1'b1;
                        o_spi_cs   <= 1'b1;
                        o_spi_we   <= 1'b1;
                        o_spi_addr <= SPI_CTL;
                        o_spi_dat  <= ctl_word(DIV, SS_ACTIVE);
                        state      <= S_SS_ON;
                    end
                end
                S_SS_ON: begin
                    o_spi_cs   <= 1'b1;
                    o_spi_we   <= 1'b1;
                    o_spi_addr <= SPI_DATA;
                    o_spi_dat  <= tx_byte(idx, addr_q);
                    state      <= S_SEND;
                end
                S_SEND: begin
                    o_spi_addr <= SPI_DATA;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_spi_irq) begin
                        rx <= i_spi_dat;
                        if (idx < 17'(HDR_BYTES)) begin
                            idx   <= idx + 17'd1;
                            state <= S_NEXT;
                        end else begin
                            o_valid <= 1'b1;
                            o_data  <= i_spi_dat;
                            state   <= S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        idx     <= idx + 17'd1;
                        state   <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    o_spi_cs <= 1'b1;
                    o_spi_we <= 1'b1;
                    if (idx == end_idx) begin
                        o_spi_addr <= SPI_CTL;
                        o_spi_dat  <= ctl_word(DIV, ~SS_ACTIVE);
                        state      <= S_SS_OFF;
                    end else begin
                        o_spi_addr <= SPI_DATA;
                        o_spi_dat  <= tx_byte(idx, addr_q);
                        state      <= S_SEND;
                    end
                end
                S_SS_OFF: begin
                    o_done <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural SPI master/flash model
// answering each data-register write with a delayed one-cycle irq and a MISO byte.
module tb_spi_flash_reader;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [23:0] i_addr = '0;
    logic [15:0] i_len = '0;
    logic        i_ready = 1'b1;
    logic [7:0]  i_spi_dat = '0;
    logic        i_spi_irq = 1'b0;
    logic        o_busy, o_done, o_valid;
    logic [7:0]  o_data;
    logic        o_spi_addr, o_spi_cs, o_spi_we;
    logic [7:0]  o_spi_dat;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    int st_cnt = 0;
    int valid_cycles = 0;
    int spi_t = 3;
    int cnt = 0;
    int tx_count = 0;
    logic [7:0] pend = '0;
    logic s_wr_data = 1'b0;
    logic s_ss_on = 1'b0;

    logic [31:0] tx_q[$];
    logic [31:0] st_q[$];
    logic [7:0]  flash_q[$];

    spi_flash_reader dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_addr(i_addr),
        .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_valid(o_valid),
        .o_data(o_data), .i_ready(i_ready), .o_spi_addr(o_spi_addr), .o_spi_cs(o_spi_cs),
        .o_spi_we(o_spi_we), .o_spi_dat(o_spi_dat), .i_spi_dat(i_spi_dat), .i_spi_irq(i_spi_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: compares every bus write and every stream handshake against the queues.
    initial forever begin
        @(negedge i_clk);
        s_wr_data = o_spi_cs && o_spi_we && o_spi_addr;
        s_ss_on   = o_spi_cs && o_spi_we && !o_spi_addr && o_spi_dat[0];
        if (i_reset_n) begin
            if (o_spi_cs && o_spi_we) begin
                if (tx_q.size() == 0) checkOutput("spi_write_unexpected", 32'({o_spi_addr, o_spi_dat}), 32'hDEAD);
                else checkOutput("spi_write", 32'({o_spi_addr, o_spi_dat}), tx_q.pop_front());
            end
            if (o_valid) valid_cycles++;
            if (o_valid && i_ready) begin
                st_cnt++;
                if (st_q.size() == 0) checkOutput("stream_unexpected", 32'(o_data), 32'hDEAD);
                else checkOutput("stream_data", 32'(o_data), st_q.pop_front());
            end
            if (o_done) done_cnt++;
        end
    end

    // SPI master + flash model: header bytes answer C0+n, data bytes come from flash_q.
    initial forever begin
        @(posedge i_clk);
        #1;
        i_spi_irq = 1'b0;
        if (!i_reset_n) cnt = 0;
        else begin
            if (s_ss_on) tx_count = 0;
            if (s_wr_data) begin
                if (tx_count < 4) pend = 8'hC0 | 8'(tx_count);
                else if (flash_q.size() != 0) pend = flash_q.pop_front();
                else pend = 8'hEE;
                tx_count++;
                cnt = spi_t;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    i_spi_irq = 1'b1;
                    i_spi_dat = pend;
                end
            end
        end
    end

    task automatic expectTx(input logic [23:0] a, input int zeros, input bit with_off);
        tx_q.push_back(32'h005);
        tx_q.push_back(32'h103);
        tx_q.push_back(32'h100 | 32'(a[23:16]));
        tx_q.push_back(32'h100 | 32'(a[15:8]));
        tx_q.push_back(32'h100 | 32'(a[7:0]));
        for (int i = 0; i < zeros; i++) tx_q.push_back(32'h100);
        if (with_off) tx_q.push_back(32'h004);
    endtask

    task automatic expectByte(input logic [7:0] b);
        flash_q.push_back(b);
        st_q.push_back(32'(b));
    endtask

    task automatic applyStimulus(input logic [23:0] a, input logic [15:0] l);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_addr = a; i_len = l;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_addr = '0; i_len = '0;
        @(negedge i_clk);
        checkOutput("start_latency", 32'({o_busy, o_spi_cs, o_spi_addr}), 32'b110);
    endtask

    task automatic waitDone(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        checkOutput("done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (5) @(negedge i_clk);
        checkOutput("done_once", 32'(done_cnt - d0), 32'd1);
        checkOutput("idle_busy", 32'(o_busy), 32'd0);
        checkOutput("tx_drained", 32'(tx_q.size()), 32'd0);
        checkOutput("stream_drained", 32'(st_q.size()), 32'd0);
    endtask

    task automatic pulseReset();
        @(posedge i_clk); #3;
        i_reset_n = 1'b0;
        #1;
        checkOutput("reset_outputs",
            32'({o_busy, o_done, o_valid, o_data, o_spi_cs, o_spi_we, o_spi_addr, o_spi_dat}), 32'd0);
        tx_q.delete(); st_q.delete(); flash_q.delete();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int n;
        int v0;
        int s0;
        #2;
        checkOutput("reset_state",
            32'({o_busy, o_done, o_valid, o_data, o_spi_cs, o_spi_we, o_spi_addr, o_spi_dat}), 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        $display("[TB] basic read, ready high");
        expectTx(24'h012345, 2, 1'b1);
        expectByte(8'hAA); expectByte(8'h55);
        applyStimulus(24'h012345, 16'd2);
        waitDone(500);

        $display("[TB] backpressure on first data byte");
        expectTx(24'h012345, 2, 1'b1);
        expectByte(8'hAA); expectByte(8'h55);
        i_ready = 1'b0;
        applyStimulus(24'h012345, 16'd2);
        n = 0;
        while (!o_valid && n < 300) begin @(negedge i_clk); n++; end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ok &= (o_valid === 1'b1) && (o_data === 8'hAA) && (o_spi_cs === 1'b0);
            @(negedge i_clk);
        end
        checkOutput("stall_hold", 32'(ok), 32'd1);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        waitDone(500);

        $display("[TB] zero length");
        v0 = valid_cycles;
        expectTx(24'hC0FFEE, 0, 1'b1);
        applyStimulus(24'hC0FFEE, 16'd0);
        waitDone(400);
        checkOutput("len0_no_valid", 32'(valid_cycles - v0), 32'd0);

        $display("[TB] start while busy is ignored");
        expectTx(24'h0A0B0C, 1, 1'b1);
        expectByte(8'h96);
        applyStimulus(24'h0A0B0C, 16'd1);
        repeat (12) @(posedge i_clk);
        #1;
        i_start = 1'b1; i_addr = 24'h777777; i_len = 16'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_addr = '0; i_len = '0;
        waitDone(500);

        $display("[TB] async reset during WAIT of data byte 2");
        expectTx(24'h000100, 4, 1'b1);
        expectByte(8'h11); expectByte(8'h22); expectByte(8'h33); expectByte(8'h44);
        s0 = st_cnt;
        applyStimulus(24'h000100, 16'd4);
        n = 0;
        while (st_cnt - s0 < 2 && n < 400) begin @(negedge i_clk); n++; end
        n = 0;
        while (!s_wr_data && n < 50) begin @(negedge i_clk); n++; end
        checkOutput("reached_byte2", 32'(st_cnt - s0), 32'd2);
        pulseReset();
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            ok &= (o_busy === 1'b0) && (o_spi_cs === 1'b0) && (o_valid === 1'b0);
        end
        checkOutput("idle_after_reset", 32'(ok), 32'd1);
        expectTx(24'hFEDCBA, 1, 1'b1);
        expectByte(8'h3C);
        applyStimulus(24'hFEDCBA, 16'd1);
        waitDone(400);

        $display("[TB] full length spot-check");
        spi_t = 1;
        expectTx(24'h000000, 64, 1'b0);
        for (int i = 0; i < 40; i++) expectByte(8'(i) ^ 8'h5A);
        s0 = st_cnt;
        v0 = done_cnt;
        applyStimulus(24'h000000, 16'hFFFF);
        n = 0;
        while (st_cnt - s0 < 40 && n < 2000) begin @(negedge i_clk); n++; end
        checkOutput("ffff_stream_count", 32'(st_cnt - s0), 32'd40);
        checkOutput("ffff_still_busy", 32'(o_busy), 32'd1);
        checkOutput("ffff_no_done", 32'(done_cnt - v0), 32'd0);
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        pulseReset();
        i_ready = 1'b1;
        repeat (3) @(negedge i_clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Command sequencer that sits directly upstream of the byte-level SPI master and drives its two-register bus interface. On a host start request it asserts slave-select, issues an 8-bit read opcode plus 24-bit address, clocks out `len` dummy bytes, and forwards each received byte on a valid/ready stream. It then releases slave-select and pulses done. It lets boot logic stream SPI-flash contents without per-byte CPU involvement.

## Interface
Parameters:
- `CMD`, 8'h03, read opcode sent first.
- `DIV`, 3'd2, SCK divider written into SPI ctl bits [3:1].
- `SS_ACTIVE`, 1'b1, value written to SPI ctl bit 0 to select the device; release writes the inverse.

Ports:
- `i_clk` in 1: single clock; all logic is on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: start request, sampled in IDLE only.
- `i_addr` in 24: flash byte address, latched on accepted start.
- `i_len` in 16: number of data bytes to read, latched on accepted start.
- `o_busy` in/out: out 1, high from the cycle after an accepted start until DONE exits.
- `o_done` out 1: one-cycle pulse at the end of a transaction.
- `o_valid` out 1: stream data valid.
- `o_data` out 8: stream data.
- `i_ready` in 1: stream ready.
- `o_spi_addr` out 1: SPI register select (0 = ctl/status, 1 = rx/tx).
- `o_spi_cs` out 1: SPI bus strobe.
- `o_spi_we` out 1: SPI write enable.
- `o_spi_dat` out 8: SPI write data.
- `i_spi_dat` in 8: SPI read data (combinational from the SPI master).
- `i_spi_irq` in 1: SPI byte-complete pulse, one cycle long.

## Operation
- States:
  - IDLE: if `i_start` is high, latch addr/len, clear byte index `idx`, go to SS_ON.
  - SS_ON: one cycle; `cs=1, we=1, addr=0, dat={4'b0, DIV, SS_ACTIVE}`; go to SEND.
  - SEND: one cycle; `cs=1, we=1, addr=1`; `dat` is selected by `idx`:
    - idx 0: `CMD`
    - idx 1: `addr[23:16]`
    - idx 2: `addr[15:8]`
    - idx 3: `addr[7:0]`
    - idx ≥ 4: 8'h00
  - SEND then goes to WAIT.
  - WAIT: `o_spi_addr=1`, `cs=0`. On `i_spi_irq`, capture `i_spi_dat` into `rx` the same cycle. Then:
    - if idx < 4: increment idx and go to NEXT.
    - else: go to PUSH.
  - PUSH: `o_valid=1`, `o_data=rx`, held stable until `i_ready`. On handshake, increment idx and go to NEXT.
  - NEXT: if `idx == len + 4`, go to SS_OFF; else go to SEND.
  - SS_OFF: one cycle; ctl write with bit 0 = `~SS_ACTIVE`, same DIV; go to DONE.
  - DONE: `o_done=1` for one cycle; go to IDLE.
- Header received bytes (idx 0..3) are discarded, never streamed.
- `i_len = 0`: header only, no stream output, then SS_OFF/DONE.
- `idx` is 17 bits wide. `len + 4` is computed at 17 bits, so `i_len = 16'hFFFF` does not wrap.
- `i_start` outside IDLE is ignored; there is no queueing.
- `o_spi_cs = 0` in every state except SS_ON, SEND and SS_OFF.
- `i_spi_irq` outside WAIT is ignored.
- Reset (async, any state): state returns to IDLE. Slave-select is not actively released by this block; the SPI master's own reset covers it.

## Timing
- Reset values: `o_busy=0`, `o_done=0`, `o_valid=0`, `o_data=0`, `o_spi_cs=0`, `o_spi_we=0`, `o_spi_addr=0`, `o_spi_dat=0`; `idx`, `rx`, latched addr/len all 0.
- Start accepted at edge N: SS_ON write occurs in cycle N+1, first SEND in cycle N+2.
- Earliest next SEND after a header irq is 2 cycles later (WAIT→NEXT→SEND). This guarantees the SPI master has left its IRQ state.
- Data bytes: irq at cycle M gives `o_valid` from M+1. Handshake at cycle K gives NEXT at K+1 and SEND at K+2.
- Total transaction with `i_ready` tied high: 1 + (4+len)×(3 + spi_byte_time) + the data-byte PUSH cycles + 2 cycles.

## Structure
- Shared package `spi_pkg`:
  - SPI register addresses (CTL=0, DATA=1).
  - ctl bit positions (SS=0, DIV=3:1, BUSY=7).
  - flash opcode constant `FLASH_READ=8'h03`.
  - header length constant `HDR_BYTES=4`.
- The state enum is local to the block.
- No sub-modules. For the bench, integrate with the existing SPI master; MISO comes from a behavioural flash model.

## Test plan
- Start with addr=24'h012345, len=2, model bytes AA, 55, `i_ready=1` → SPI TX sequence 03 01 23 45 00 00; stream AA then 55; one `o_done` pulse; ctl writes 8'h05 then 8'h04 (DIV=2).
- Same, with `i_ready` low for 10 cycles on byte 0 → `o_valid`/`o_data`=AA held; no SEND until the handshake; stream order unchanged.
- len=0 → four header writes, `o_valid` never high, then SS_OFF, DONE.
- `i_start` pulsed while busy → ignored; exactly one `o_done`; the second request's addr is not latched.
- `i_reset_n` low during WAIT of byte 2 → all outputs at reset values immediately; IDLE afterwards; a subsequent start completes normally.
- len=16'hFFFF (spot-check, accelerated SPI model) → 65535 stream bytes, no early termination from wrap.
